adc_serial_readout: RTL and testbench
=====================================

Name: adc_serial_readout

Overview:
- Downstream consumer of the digital filter's serial output port.
- On each filter `new_data` pulse it generates the `shift` strobe, deserializes the DATA_W-bit word MSB-first from `serial_data_out`, and buffers words in a small FIFO.
- Words leave through a valid/ready interface toward the chip readout/SPI logic.
- Flags dropped and missed samples with sticky error bits.

Parameters:
- DATA_W, 12: word width; equals the filter output width.
- FIFO_DEPTH, 4: number of FIFO entries; power of two, at least 2.
- SHIFT_DIV, 1: clk cycles per shift strobe; at least 1.

Ports:
- clk  in  1  system clock, same domain as the digital filter.
- rst  in  1  synchronous, active-high reset.
- new_data  in  1  one-cycle load pulse from the filter; the filter's shift register loads on this edge.
- serial_in  in  1  connects to filter `serial_data_out`; MSB is presented first.
- shift  out  1  shift strobe to the filter's shift register.
- word_out  out  DATA_W  FIFO head word.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts `word_out`.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- miss  out  1  sticky: `new_data` arrived while a capture was in progress.
- err_clr  in  1  clears `ovf` and `miss`.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE; shift=0; word_valid=0; word_out=0; fifo_level=0; ovf=0; miss=0.
  - Bit counter, divider and accumulator are all cleared.
  - A reset mid-capture abandons the partial word; nothing is pushed.
- FSM states IDLE, SHIFT, PUSH:
  - IDLE: `new_data`=1 at edge T moves to SHIFT for cycle T+1; the divider and bit counter are set to 0.
  - SHIFT, divider: counts 0..SHIFT_DIV-1. `shift` is registered and is high only in the cycle where divider==SHIFT_DIV-1 (always high when SHIFT_DIV=1).
  - SHIFT, capture: on each edge with shift=1, acc <= {acc[DATA_W-2:0], serial_in} and the bit counter increments.
  - SHIFT, exit: after the DATA_W-th capture, go to PUSH. With SHIFT_DIV=1, shift is high in cycles T+1..T+DATA_W.
  - PUSH (one cycle): pushes acc into the FIFO, then returns to IDLE. shift=0.
  - Back-to-back: `new_data` in the PUSH cycle or later starts a new capture normally.
- Latency (SHIFT_DIV=1): `new_data` at T gives the FIFO write at the end of T+DATA_W+1. word_valid rises in cycle T+DATA_W+2 if the FIFO was empty (cycle T+14 for DATA_W=12).
- miss:
  - `new_data`=1 while in SHIFT sets `miss`.
  - The current capture continues unchanged; its word is pushed as-is (the upstream reload corrupts it; the consumer is told by `miss`).
  - The pulse does not start a new capture.
- FIFO:
  - Synchronous, registered pointers; word_out = mem[rd_ptr].
  - Pop when word_valid && word_ready.
  - Push in PUSH is accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle. Simultaneous push and pop at level=FIFO_DEPTH leaves the level unchanged.
  - A push at full with no pop is dropped and sets `ovf`.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop when empty is ignored.
  - word_out and word_valid are stable while word_valid=1 and word_ready=0.
- Sticky flags:
  - Cleared by err_clr.
  - If err_clr and a set event occur in the same cycle, set wins.

Optional Feature:
- Macro: ADC_READOUT_SEQ_EN.
- Defined:
  - Adds output `seq_out[3:0]`, stored alongside each FIFO entry.
  - A 4-bit counter increments on every completed capture, including dropped ones, wrapping 15->0.
  - seq_out shows the head entry's tag, so gaps reveal drops.
  - The counter resets to 0.
- Undefined: no seq_out port and no counter or storage.

Test Plan:
- Single word: model shift register loaded with 12'hA5C, `new_data` at T, word_ready=1 -> shift high in exactly cycles T+1..T+12; word_valid high in cycle T+14 with word_out=12'hA5C; then fifo_level returns to 0.
- SHIFT_DIV=3, word 12'h801 -> 12 shift pulses spaced 3 cycles apart; captured word equals 12'h801 (MSB and LSB ordering check).
- Overflow: word_ready=0, five captures of 12'h001..12'h005 with FIFO_DEPTH=4 -> fifo_level=4, ovf=1; draining yields 001,002,003,004; err_clr -> ovf=0.
- Full with simultaneous pop: FIFO full, word_ready=1 during the PUSH cycle -> new word accepted, level stays 4, ovf stays 0.
- Collision: second `new_data` at T+5 -> miss=1; only one word is pushed, at T+13; no extra shift pulses.
- Reset mid-capture: rst at T+6 -> shift=0 next cycle, nothing pushed, word_valid=0. A later `new_data` with 12'h3FF captures correctly; with ADC_READOUT_SEQ_EN its seq_out=0.

Source files
------------

// File: rtl/adc_serial_readout.sv
// Deserialising readout for the digital filter's serial port, with an output FIFO and sticky error flags.
// Optional: define ADC_READOUT_SEQ_EN to add a 4-bit sequence tag (seq_out) per captured word.
module adc_serial_readout #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_DIV  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_data,
  input  logic                          serial_in,
  output logic                          shift,
  output logic [DATA_W-1:0]             word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  output logic                          miss,
  input  logic                          err_clr
`ifdef ADC_READOUT_SEQ_EN
  ,
  output logic [3:0]                    seq_out
`endif
);

  // state | meaning
  // IDLE  | waiting for new_data
  // SHIFT | strobing shift and capturing serial_in MSB-first
  // PUSH  | one cycle: write the captured word into the FIFO
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PUSH  = 2'd2;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [DW-1:0]     div;
  logic [DW-1:0]     div_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic push;
  logic pop;
  logic push_ok;
  logic ovf_set;
  logic miss_set;

  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;

  // shift is registered: it is raised for the cycle in which the divider reaches its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      acc     <= '0;
      shift   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_PUSH: begin
          if (new_data) begin
            state   <= ST_SHIFT;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= (SHIFT_DIV == 1);
          end else begin
            state <= ST_IDLE;
            shift <= 1'b0;
          end
        end
        ST_SHIFT: begin
          div   <= div_nxt;
          shift <= (div_nxt == DIV_LAST);
          if (shift) begin
            acc     <= {acc[DATA_W-2:0], serial_in};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_PUSH;
              shift <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          shift <= 1'b0;
        end
      endcase
    end
  end

  assign word_valid = (fifo_level != '0);
  assign push       = (state == ST_PUSH);
  assign pop        = word_valid && word_ready;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok    = push && ((fifo_level != FULL_LVL) || pop);
  assign ovf_set    = push && !push_ok;
  assign miss_set   = new_data && (state == ST_SHIFT);

  assign word_out   = word_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf  <= 1'b0;
      miss <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (miss_set) begin
        miss <= 1'b1;
      end else if (err_clr) begin
        miss <= 1'b0;
      end
    end
  end

`ifdef ADC_READOUT_SEQ_EN
  logic [3:0] seq_cnt;
  logic [3:0] seq_mem [FIFO_DEPTH];

  // Tag advances on every completed capture, dropped ones included, so gaps expose drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      seq_mem[wr_ptr] <= seq_cnt;
    end
  end

  assign seq_out = word_valid ? seq_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_adc_serial_readout.sv
// Bench for adc_serial_readout: filter shift-register models, a cycle-timeline reference model, and directed tests.
module tb_adc_serial_readout;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        new_data = 1'b0;
  logic        word_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] load_word = '0;
  logic [11:0] sreg = '0;
  wire         serial_in = sreg[11];
  logic        shift;
  logic [11:0] word_out;
  logic        word_valid;
  logic [2:0]  fifo_level;
  logic        ovf, miss;

  logic        new_data3 = 1'b0;
  logic        word_ready3 = 1'b1;
  logic        err_clr3 = 1'b0;
  logic [11:0] load3 = '0;
  logic [11:0] sreg3 = '0;
  wire         serial_in3 = sreg3[11];
  logic        shift3;
  logic [11:0] word_out3;
  logic        word_valid3;
  logic [2:0]  fifo_level3;
  logic        ovf3, miss3;
`ifdef ADC_READOUT_SEQ_EN
  logic [3:0]  seq_out, seq_out3;
`endif

  adc_serial_readout #(.DATA_W(12), .FIFO_DEPTH(4), .SHIFT_DIV(1)) dut (
    .clk(clk), .rst(rst), .new_data(new_data), .serial_in(serial_in), .shift(shift),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_level(fifo_level), .ovf(ovf), .miss(miss), .err_clr(err_clr)
`ifdef ADC_READOUT_SEQ_EN
    , .seq_out(seq_out)
`endif
  );

  adc_serial_readout #(.DATA_W(12), .FIFO_DEPTH(4), .SHIFT_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .new_data(new_data3), .serial_in(serial_in3), .shift(shift3),
    .word_out(word_out3), .word_valid(word_valid3), .word_ready(word_ready3),
    .fifo_level(fifo_level3), .ovf(ovf3), .miss(miss3), .err_clr(err_clr3)
`ifdef ADC_READOUT_SEQ_EN
    , .seq_out(seq_out3)
`endif
  );

  // Upstream filter: loads on new_data, shifts left on each strobe, MSB on the wire.
  always @(posedge clk) begin
    if (new_data) sreg <= load_word;
    else if (shift) sreg <= {sreg[10:0], 1'b0};
    if (new_data3) sreg3 <= load3;
    else if (shift3) sreg3 <= {sreg3[10:0], 1'b0};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture started in cycle S strobes in S+1..S+DATA_W and pushes in S+DATA_W+1.
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [11:0] m_bits = '0;
  logic [11:0] m_q[$];
  bit          m_ovf = 1'b0, m_miss = 1'b0;
  bit          in_shift, push_now, m_pop, set_o, set_m;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_ovf = 1'b0;
      m_miss = 1'b0;
    end else begin
      in_shift = m_active && (cyc >= m_start + 1) && (cyc <= m_start + DATA_W);
      push_now = m_active && (cyc == m_start + DATA_W + 1);
      m_pop    = (m_q.size() > 0) && word_ready;
      set_m    = new_data && in_shift;
      set_o    = 1'b0;
      if (in_shift) m_bits = {m_bits[10:0], serial_in};
      if (m_pop) void'(m_q.pop_front());
      if (push_now) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_bits);
        else set_o = 1'b1;
        m_active = 1'b0;
      end
      if (new_data && !m_active) begin
        m_active = 1'b1;
        m_start  = cyc;
      end
      m_ovf  = set_o ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_miss = set_m ? 1'b1 : (err_clr ? 1'b0 : m_miss);
    end
    cyc = cyc + 1;
  end

  bit chk_en = 1'b0;
  bit exp_shift;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_shift = m_active && (cyc >= m_start + 1) && (cyc <= m_start + DATA_W);
      chk("m_shift", shift, exp_shift);
      chk("m_valid", word_valid, m_q.size() > 0);
      chk("m_word", word_out, (m_q.size() > 0) ? m_q[0] : 12'h000);
      chk("m_level", fifo_level, m_q.size());
      chk("m_ovf", ovf, m_ovf);
      chk("m_miss", miss, m_miss);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input logic [11:0] w);
    load_word = w;
    new_data  = 1'b1;
    tick();
    new_data  = 1'b0;
  endtask

  int          n3, prev3, first3, valid_k3, nsh, nval, val_k;
  bit          gap_ok, seen3;
  logic [11:0] got3, got_col;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_shift", shift, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_miss", miss, 0);
`ifdef ADC_READOUT_SEQ_EN
    chk("rst_seq", seq_out, 0);
    chk("rst_seq3", seq_out3, 0);
`endif

    // Single word, SHIFT_DIV=1
    word_ready = 1'b1;
    start_cap(12'hA5C);
    for (int k = 1; k <= 14; k++) begin
      chk("t1_shift", shift, (k <= 12) ? 1 : 0);
      if (k == 13) chk("t1_valid_early", word_valid, 0);
      if (k == 14) begin
        chk("t1_valid", word_valid, 1);
        chk("t1_word", word_out, 12'hA5C);
      end
      if (k < 14) tick();
    end
    tick();
    chk("t1_level_after", fifo_level, 0);

    // SHIFT_DIV=3 instance, MSB/LSB ordering
    load3 = 12'h801;
    new_data3 = 1'b1;
    tick();
    new_data3 = 1'b0;
    n3 = 0; prev3 = -1; first3 = -1; valid_k3 = -1; gap_ok = 1'b1; seen3 = 1'b0; got3 = '0;
    for (int k = 1; k <= 80 && !seen3; k++) begin
      if (shift3) begin
        if (prev3 >= 0 && (k - prev3) != 3) gap_ok = 1'b0;
        if (first3 < 0) first3 = k;
        prev3 = k;
        n3++;
      end
      if (word_valid3) begin
        seen3 = 1'b1;
        got3 = word_out3;
        valid_k3 = k;
      end
      tick();
    end
    chk("div3_seen", seen3, 1);
    chk("div3_pulses", n3, 12);
    chk("div3_first", first3, 3);
    chk("div3_spacing", gap_ok, 1);
    chk("div3_latency", valid_k3, 38);
    chk("div3_word", got3, 12'h801);
    chk("div3_flags", {ovf3, miss3}, 0);
    repeat (3) tick();
    chk("div3_level", fifo_level3, 0);

    // Overflow with consumer stalled
    word_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      start_cap(12'(i));
      repeat (13) tick();
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", ovf, 1);
    chk("ovf_miss", miss, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", word_out, 12'(i));
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
    end
    chk("ovf_empty", fifo_level, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Full FIFO with a pop in the PUSH cycle
    for (int i = 1; i <= 4; i++) begin
      start_cap(12'h010 + 12'(i));
      repeat (13) tick();
    end
    chk("full_level", fifo_level, 4);
    start_cap(12'h015);
    repeat (12) tick();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("full_pop_level", fifo_level, 4);
    chk("full_pop_ovf", ovf, 0);
    chk("full_pop_head", word_out, 12'h012);
    for (int i = 2; i <= 5; i++) begin
      chk("full_drain", word_out, 12'h010 + 12'(i));
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
    end
    chk("full_empty", fifo_level, 0);

    // Collision: second new_data at T+5 together with err_clr (set wins)
    word_ready = 1'b1;
    start_cap(12'h5A5);
    repeat (4) tick();
    load_word = 12'h0F0;
    new_data = 1'b1;
    err_clr = 1'b1;
    tick();
    new_data = 1'b0;
    err_clr = 1'b0;
    chk("col_miss", miss, 1);
    nsh = 0; nval = 0; val_k = -1; got_col = '0;
    for (int k = 6; k <= 40; k++) begin
      if (shift) nsh++;
      if (word_valid) begin
        nval++;
        if (val_k < 0) begin
          val_k = k;
          got_col = word_out;
        end
      end
      tick();
    end
    chk("col_shift_rest", nsh, 7);
    chk("col_one_word", nval, 1);
    chk("col_valid_cycle", val_k, 14);
    chk("col_word", got_col, 12'h587);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("col_miss_clr", miss, 0);

    // Reset mid-capture
    start_cap(12'h123);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_shift", shift, 0);
    chk("rmid_valid", word_valid, 0);
    nval = 0;
    for (int k = 0; k < 16; k++) begin
      if (word_valid) nval++;
      tick();
    end
    chk("rmid_nothing", nval, 0);
    start_cap(12'h3FF);
    for (int k = 0; k < 40 && !word_valid; k++) tick();
    chk("rmid_valid_after", word_valid, 1);
    chk("rmid_word", word_out, 12'h3FF);
`ifdef ADC_READOUT_SEQ_EN
    chk("rmid_seq", seq_out, 0);
`endif
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
